// File: rtl/fetch.sv
`timescale 1ns/1ps
`default_nettype none
// fetch: PC holder issuing one instruction read at a time, with a 1-entry skid buffer.
// Rev 1.0
module fetch #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] NEW_PC,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_READY,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] I_PC,
  output logic [31:0] I_INST,
  output logic        I_VALID
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, req_pc;
  logic [31:0] out_pc, out_inst, skid_pc, skid_inst;
  logic        out_v, skid_v, discard;
  logic        req, accept, resp, take;

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    MEM_ADDR  = req_pc;
    case (state)
      S_REQ: begin
        req      = !skid_v && !FLUSH && !RST;
        MEM_ADDR = pc;
        if (req && MEM_READY) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (MEM_RVALID) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  assign MEM_REQ = req;
  assign accept  = req && MEM_READY;
  // A response is only real when it belongs to a request that survived any flush.
  assign resp    = (state == S_WAIT) && MEM_RVALID && !discard;
  // Output register may be overwritten when empty or when decode takes it this edge.
  assign take    = !out_v || !STALL;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_REQ;
      pc        <= START_ADDR;
      req_pc    <= START_ADDR;
      out_pc    <= 32'h0;
      out_inst  <= NOP;
      out_v     <= 1'b0;
      skid_pc   <= 32'h0;
      skid_inst <= NOP;
      skid_v    <= 1'b0;
      discard   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) req_pc <= pc;
      if (FLUSH) begin
        pc     <= NEW_PC;
        out_v  <= 1'b0;
        skid_v <= 1'b0;
        // A flushed in-flight request with no data yet must have its late response dropped.
        if (state == S_WAIT) discard <= !MEM_RVALID;
      end else begin
        if ((state == S_WAIT) && MEM_RVALID) begin
          if (discard) discard <= 1'b0;
          else         pc      <= req_pc + 32'd4;
        end
        if (take) begin
          if (skid_v) begin
            out_pc   <= skid_pc;
            out_inst <= skid_inst;
            out_v    <= 1'b1;
            skid_v   <= resp;
            if (resp) begin
              skid_pc   <= req_pc;
              skid_inst <= MEM_RDATA;
            end
          end else if (resp) begin
            out_pc   <= req_pc;
            out_inst <= MEM_RDATA;
            out_v    <= 1'b1;
          end else begin
            out_v <= 1'b0;
          end
        end else if (resp) begin
          skid_pc   <= req_pc;
          skid_inst <= MEM_RDATA;
          skid_v    <= 1'b1;
        end
      end
    end
  end

  assign I_PC    = out_pc;
  assign I_INST  = out_inst;
  assign I_VALID = out_v;

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// tb_fetch: directed self-checking bench for the fetch stage with a latency-programmable memory.
// Rev 1.0
module tb_fetch;

  localparam logic [31:0] MASK = 32'hA5A5_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] NEW_PC = 32'h0;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_READY = 1'b1;
  logic        MEM_RVALID = 1'b0;
  logic [31:0] MEM_RDATA = 32'hDEAD_BEEF;
  logic [31:0] I_PC;
  logic [31:0] I_INST;
  logic        I_VALID;

  int passed = 0;
  int total  = 0;
  int lat    = 1;

  fetch #(.START_ADDR(32'h0000_0100)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .NEW_PC(NEW_PC),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_READY(MEM_READY),
    .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .I_PC(I_PC), .I_INST(I_INST), .I_VALID(I_VALID)
  );

  initial forever #5 CLK = ~CLK;

  // Memory: accepts on REQ&&READY, answers addr^MASK exactly 'lat' cycles later.
  initial begin
    logic        acc, rst_s, pend;
    logic [31:0] acc_addr, paddr;
    int          cnt;
    pend = 1'b0;
    cnt = 0;
    paddr = 32'h0;
    forever begin
      @(negedge CLK);
      acc      = MEM_REQ && MEM_READY;
      acc_addr = MEM_ADDR;
      rst_s    = RST;
      @(posedge CLK);
      #1;
      MEM_RVALID = 1'b0;
      MEM_RDATA  = 32'hDEAD_BEEF;
      if (rst_s) begin
        pend = 1'b0;
      end else begin
        if (acc) begin
          pend  = 1'b1;
          cnt   = lat;
          paddr = acc_addr;
        end
        if (pend) begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            MEM_RVALID = 1'b1;
            MEM_RDATA  = paddr ^ MASK;
            pend       = 1'b0;
          end
        end
      end
    end
  end

  task automatic apply_reset();
    RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0; NEW_PC = 32'h0; MEM_READY = 1'b1; lat = 1;
    repeat (2) begin @(posedge CLK); #1; end
    RST = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++; if (MEM_REQ !== 1'b0) $display("FAIL reset_mem_req: got %b, expected 0", MEM_REQ); else passed++;
    total++; if (I_VALID !== 1'b0) $display("FAIL reset_i_valid: got %b, expected 0", I_VALID); else passed++;
    total++; if (I_INST !== NOP) $display("FAIL reset_i_inst: got %h, expected %h", I_INST, NOP); else passed++;
    total++; if (I_PC !== 32'h0) $display("FAIL reset_i_pc: got %h, expected 0", I_PC); else passed++;
    total++; if (MEM_ADDR !== 32'h100) $display("FAIL reset_mem_addr: got %h, expected 100", MEM_ADDR); else passed++;
  endtask

  task automatic test_basic();
    logic [0:6]  req_t = 7'b1010101;
    logic [0:6]  iv_t  = 7'b0010101;
    logic [31:0] addr_t [7] = '{32'h100, 32'h100, 32'h104, 32'h104, 32'h108, 32'h108, 32'h10C};
    logic [31:0] pc_t   [7] = '{32'h0, 32'h0, 32'h100, 32'h0, 32'h104, 32'h0, 32'h108};
    logic [97:0] obs, expv;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      obs  = {MEM_REQ, MEM_ADDR, I_VALID, iv_t[i] ? I_PC : 32'h0, iv_t[i] ? I_INST : 32'h0};
      expv = {req_t[i], addr_t[i], iv_t[i], iv_t[i] ? pc_t[i] : 32'h0, iv_t[i] ? (pc_t[i] ^ MASK) : 32'h0};
      total++;
      if (obs !== expv) $display("FAIL basic c%0d: got %h, expected %h", i, obs, expv);
      else passed++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_stall();
    logic [0:12] st_t  = 13'b0000111110000;
    logic [0:12] req_t = 13'b1010100000101;
    logic [0:12] iv_t  = 13'b0010111111101;
    logic [31:0] addr_t [13] = '{32'h100, 32'h100, 32'h104, 32'h104, 32'h108, 32'h108, 32'h10C,
                                 32'h10C, 32'h10C, 32'h10C, 32'h10C, 32'h10C, 32'h110};
    logic [31:0] pc_t   [13] = '{32'h0, 32'h0, 32'h100, 32'h0, 32'h104, 32'h104, 32'h104,
                                 32'h104, 32'h104, 32'h104, 32'h108, 32'h0, 32'h10C};
    logic [97:0] obs, expv;
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      STALL = st_t[i];
      @(negedge CLK);
      obs  = {MEM_REQ, MEM_ADDR, I_VALID, iv_t[i] ? I_PC : 32'h0, iv_t[i] ? I_INST : 32'h0};
      expv = {req_t[i], addr_t[i], iv_t[i], iv_t[i] ? pc_t[i] : 32'h0, iv_t[i] ? (pc_t[i] ^ MASK) : 32'h0};
      total++;
      if (obs !== expv) $display("FAIL stall c%0d: got %h, expected %h", i, obs, expv);
      else passed++;
      @(posedge CLK); #1;
    end
    STALL = 1'b0;
  endtask

  task automatic test_flush_wait();
    logic [0:12] req_t = 13'b1010101000101;
    logic [0:12] iv_t  = 13'b0010101000001;
    logic [31:0] addr_t [13] = '{32'h100, 32'h100, 32'h104, 32'h104, 32'h108, 32'h108, 32'h10C,
                                 32'h10C, 32'h10C, 32'h10C, 32'h200, 32'h200, 32'h204};
    logic [31:0] pc_t   [13] = '{32'h0, 32'h0, 32'h100, 32'h0, 32'h104, 32'h0, 32'h108,
                                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h200};
    logic [97:0] obs, expv;
    apply_reset();
    NEW_PC = 32'h200;
    for (int i = 0; i < 13; i++) begin
      if (i == 6)  lat = 3;
      if (i == 10) lat = 1;
      FLUSH = (i == 7);
      @(negedge CLK);
      obs  = {MEM_REQ, MEM_ADDR, I_VALID, iv_t[i] ? I_PC : 32'h0, iv_t[i] ? I_INST : 32'h0};
      expv = {req_t[i], addr_t[i], iv_t[i], iv_t[i] ? pc_t[i] : 32'h0, iv_t[i] ? (pc_t[i] ^ MASK) : 32'h0};
      total++;
      if (obs !== expv) $display("FAIL flush_wait c%0d: got %h, expected %h", i, obs, expv);
      else passed++;
      @(posedge CLK); #1;
    end
    FLUSH = 1'b0;
  endtask

  task automatic test_flush_same_cycle();
    logic [0:4]  req_a = 5'b10101;
    logic [0:4]  iv_a  = 5'b00001;
    logic [31:0] addr_a [5] = '{32'h100, 32'h100, 32'h300, 32'h300, 32'h304};
    logic [31:0] pc_a   [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h300};
    logic [0:9]  st_b  = 10'b0000111000;
    logic [0:9]  req_b = 10'b1010100101;
    logic [0:9]  iv_b  = 10'b0010111001;
    logic [31:0] addr_b [10] = '{32'h100, 32'h100, 32'h104, 32'h104, 32'h108, 32'h108, 32'h10C,
                                 32'h400, 32'h400, 32'h404};
    logic [31:0] pc_b   [10] = '{32'h0, 32'h0, 32'h100, 32'h0, 32'h104, 32'h104, 32'h104,
                                 32'h0, 32'h0, 32'h400};
    logic [97:0] obs, expv;
    // FLUSH coinciding with the response
    apply_reset();
    NEW_PC = 32'h300;
    for (int i = 0; i < 5; i++) begin
      FLUSH = (i == 1);
      @(negedge CLK);
      obs  = {MEM_REQ, MEM_ADDR, I_VALID, iv_a[i] ? I_PC : 32'h0, iv_a[i] ? I_INST : 32'h0};
      expv = {req_a[i], addr_a[i], iv_a[i], iv_a[i] ? pc_a[i] : 32'h0, iv_a[i] ? (pc_a[i] ^ MASK) : 32'h0};
      total++;
      if (obs !== expv) $display("FAIL flush_rvalid c%0d: got %h, expected %h", i, obs, expv);
      else passed++;
      @(posedge CLK); #1;
    end
    // FLUSH while stalled with the skid buffer occupied
    apply_reset();
    NEW_PC = 32'h400;
    for (int i = 0; i < 10; i++) begin
      STALL = st_b[i];
      FLUSH = (i == 6);
      @(negedge CLK);
      obs  = {MEM_REQ, MEM_ADDR, I_VALID, iv_b[i] ? I_PC : 32'h0, iv_b[i] ? I_INST : 32'h0};
      expv = {req_b[i], addr_b[i], iv_b[i], iv_b[i] ? pc_b[i] : 32'h0, iv_b[i] ? (pc_b[i] ^ MASK) : 32'h0};
      total++;
      if (obs !== expv) $display("FAIL flush_skid c%0d: got %h, expected %h", i, obs, expv);
      else passed++;
      @(posedge CLK); #1;
    end
    FLUSH = 1'b0;
    STALL = 1'b0;
  endtask

  task automatic test_ready_wrap();
    logic [0:9]  rdy_t = 10'b0000111111;
    logic [0:9]  req_t = 10'b1111100101;
    logic [0:9]  iv_t  = 10'b0000001001;
    logic [31:0] addr_t [10] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h104,
                                 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0};
    logic [31:0] pc_t   [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h100,
                                 32'h0, 32'h0, 32'hFFFF_FFFC};
    logic [97:0] obs, expv;
    apply_reset();
    NEW_PC = 32'hFFFF_FFFC;
    for (int i = 0; i < 10; i++) begin
      MEM_READY = rdy_t[i];
      FLUSH = (i == 6);
      @(negedge CLK);
      obs  = {MEM_REQ, MEM_ADDR, I_VALID, iv_t[i] ? I_PC : 32'h0, iv_t[i] ? I_INST : 32'h0};
      expv = {req_t[i], addr_t[i], iv_t[i], iv_t[i] ? pc_t[i] : 32'h0, iv_t[i] ? (pc_t[i] ^ MASK) : 32'h0};
      total++;
      if (obs !== expv) $display("FAIL ready_wrap c%0d: got %h, expected %h", i, obs, expv);
      else passed++;
      @(posedge CLK); #1;
    end
    FLUSH = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [0:9]  st_t  = 10'b0001100000;
    logic [0:9]  rst_t = 10'b0000110000;
    logic [0:9]  req_t = 10'b1001001001;
    logic [0:9]  iv_t  = 10'b0001100001;
    logic [31:0] addr_t [10] = '{32'h100, 32'h100, 32'h100, 32'h104, 32'h104, 32'h100, 32'h100,
                                 32'h100, 32'h100, 32'h104};
    logic [31:0] pc_t   [10] = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h100, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h100};
    logic [97:0] obs, expv;
    apply_reset();
    lat = 2;
    for (int i = 0; i < 10; i++) begin
      STALL = st_t[i];
      RST   = rst_t[i];
      @(negedge CLK);
      obs  = {MEM_REQ, MEM_ADDR, I_VALID, iv_t[i] ? I_PC : 32'h0, iv_t[i] ? I_INST : 32'h0};
      expv = {req_t[i], addr_t[i], iv_t[i], iv_t[i] ? pc_t[i] : 32'h0, iv_t[i] ? (pc_t[i] ^ MASK) : 32'h0};
      total++;
      if (obs !== expv) $display("FAIL reset_mid c%0d: got %h, expected %h", i, obs, expv);
      else passed++;
      if (i == 5) begin
        total++;
        if ({I_PC, I_INST} !== {32'h0, NOP})
          $display("FAIL reset_mid_outreg: got pc=%h inst=%h, expected pc=0 inst=%h", I_PC, I_INST, NOP);
        else passed++;
      end
      @(posedge CLK); #1;
    end
    STALL = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush_wait();
    test_flush_same_cycle();
    test_ready_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
